// File: rtl/regfile_writeback_buffer.sv
// Writeback buffer owning regfile write ports C (ALU) and D (load), one FIFO per source.
// Optional WB_BYPASS_EN: a push into an empty FIFO goes straight to its write port.

module regfile_wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers are PW bits wide, so wrap modulo DEPTH falls out of the arithmetic.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

module regfile_writeback_buffer #(
  parameter int REG_CNT               = 4,
  parameter int LOG_SUPERSCALAR_WIDTH = 4,
  parameter int REG_WIDTH             = 288,
  parameter int FIFO_DEPTH            = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     freeze,
  input  logic                                     alu_valid,
  output logic                                     alu_ready,
  input  logic [REG_CNT+LOG_SUPERSCALAR_WIDTH-1:0] alu_addr,
  input  logic [REG_WIDTH-1:0]                     alu_data,
  input  logic                                     ld_valid,
  output logic                                     ld_ready,
  input  logic [REG_CNT+LOG_SUPERSCALAR_WIDTH-1:0] ld_addr,
  input  logic [REG_WIDTH-1:0]                     ld_data,
  output logic                                     port_c_we,
  output logic [REG_CNT+LOG_SUPERSCALAR_WIDTH-1:0] port_c_write_addr,
  output logic [REG_WIDTH-1:0]                     port_c_in,
  output logic                                     port_d_we,
  output logic [REG_CNT+LOG_SUPERSCALAR_WIDTH-1:0] port_d_write_addr,
  output logic [REG_WIDTH-1:0]                     port_d_in,
  output logic                                     pending
);
  localparam int AW = REG_CNT + LOG_SUPERSCALAR_WIDTH;
  localparam int EW = AW + REG_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  // Index 0 is the ALU source / port C, index 1 the load source / port D.
  logic [1:0]          valid, ready, push, pop, fifo_push, not_empty, byp;
  logic [1:0][EW-1:0]  fifo_din, fifo_head, out_q;
  logic [1:0][AW-1:0]  head_addr;
  logic [1:0][CW-1:0]  fifo_cnt, cnt_nxt;
  logic [1:0]          we_q;
  logic                conflict, alu_byp, ld_byp;

  assign valid       = {ld_valid, alu_valid};
  assign fifo_din[0] = {alu_addr, alu_data};
  assign fifo_din[1] = {ld_addr, ld_data};

  for (genvar g = 0; g < 2; g++) begin : g_src
    assign ready[g]     = (fifo_cnt[g] < FULL) && !freeze;
    assign push[g]      = valid[g] && ready[g];
    assign not_empty[g] = (fifo_cnt[g] != '0);
    assign head_addr[g] = fifo_head[g][EW-1 -: AW];
    assign fifo_push[g] = push[g] && !byp[g];
    assign cnt_nxt[g]   = fifo_cnt[g] + CW'(fifo_push[g]) - CW'(pop[g]);

    regfile_wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push[g]),
      .pop   (pop[g]),
      .din   (fifo_din[g]),
      .head  (fifo_head[g]),
      .cnt   (fifo_cnt[g])
    );
  end

  // The ALU side always wins an address clash; the load side waits a cycle.
  always_comb begin
    alu_byp  = 1'b0;
    ld_byp   = 1'b0;
    conflict = not_empty[1] && not_empty[0] && (head_addr[0] == head_addr[1]);
`ifdef WB_BYPASS_EN
    alu_byp  = push[0] && !not_empty[0];
    ld_byp   = push[1] && !not_empty[1]
               && !(not_empty[0] && (head_addr[0] == ld_addr))
               && !(alu_byp && (alu_addr == ld_addr));
    conflict = conflict || (not_empty[1] && alu_byp && (alu_addr == head_addr[1]));
`endif
    byp    = {ld_byp, alu_byp};
    pop[0] = not_empty[0] && !freeze;
    pop[1] = not_empty[1] && !freeze && !conflict;
  end

  // Output registers hold through freeze so an already-popped entry is written once freeze drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= '0;
      out_q   <= '0;
      pending <= 1'b0;
    end else begin
      if (!freeze) begin
        for (int i = 0; i < 2; i++) begin
          we_q[i] <= pop[i] || byp[i];
          if (byp[i])      out_q[i] <= fifo_din[i];
          else if (pop[i]) out_q[i] <= fifo_head[i];
        end
      end
      pending <= (cnt_nxt[0] != '0) || (cnt_nxt[1] != '0);
    end
  end

  assign alu_ready         = ready[0];
  assign ld_ready          = ready[1];
  assign port_c_we         = we_q[0] && !freeze;
  assign port_d_we         = we_q[1] && !freeze;
  assign port_c_write_addr = out_q[0][EW-1 -: AW];
  assign port_c_in         = out_q[0][REG_WIDTH-1:0];
  assign port_d_write_addr = out_q[1][EW-1 -: AW];
  assign port_d_in         = out_q[1][REG_WIDTH-1:0];
endmodule

// File: tb/tb_regfile_writeback_buffer.sv
// Scoreboard bench for regfile_writeback_buffer: per-port expected-write queues with a negedge monitor.
module tb_regfile_writeback_buffer;
  localparam int AW    = 8;
  localparam int RW    = 288;
  localparam int DEPTH = 4;
  localparam int XW    = AW + RW;
`ifdef WB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0, reset = 1'b1, freeze = 1'b0;
  logic alu_valid = 1'b0, ld_valid = 1'b0;
  logic [AW-1:0] alu_addr = '0, ld_addr = '0;
  logic [RW-1:0] alu_data = '0, ld_data = '0;
  logic alu_ready, ld_ready, port_c_we, port_d_we, pending;
  logic [AW-1:0] port_c_write_addr, port_d_write_addr;
  logic [RW-1:0] port_c_in, port_d_in;

  always #5 clk = ~clk;

  regfile_writeback_buffer #(.REG_CNT(4), .LOG_SUPERSCALAR_WIDTH(4), .REG_WIDTH(RW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .port_c_we(port_c_we), .port_c_write_addr(port_c_write_addr), .port_c_in(port_c_in),
    .port_d_we(port_d_we), .port_d_write_addr(port_d_write_addr), .port_d_in(port_d_in),
    .pending(pending)
  );

  typedef struct packed { logic [AW-1:0] a; logic [RW-1:0] d; } ent_t;
  ent_t exp_c[$], exp_d[$];
  ent_t e_c, e_d;
  int   d_cycles[$];
  int   n_cmp = 0, n_err = 0, cyc = 0;
  int   c_wr_cyc = -1, d_wr_cyc = -1, n_c_wr = 0, n_d_wr = 0, t_push_a = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [AW-1:0] a);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got write to addr %0d, required no write", nm, a);
  endtask

  // Monitor: every regfile write must match the next expected entry of its port.
  always @(negedge clk) begin
    if (!reset) begin
      if (port_c_we) begin
        n_c_wr++;
        c_wr_cyc = cyc;
        if (exp_c.size() == 0) unexpected("c_unexpected", port_c_write_addr);
        else begin
          e_c = exp_c.pop_front();
          chk("c_write", {port_c_write_addr, port_c_in}, e_c);
        end
      end
      if (port_d_we) begin
        n_d_wr++;
        d_wr_cyc = cyc;
        d_cycles.push_back(cyc);
        if (exp_d.size() == 0) unexpected("d_unexpected", port_d_write_addr);
        else begin
          e_d = exp_d.pop_front();
          chk("d_write", {port_d_write_addr, port_d_in}, e_d);
        end
      end
      if (port_c_we && port_d_we)
        chk("cd_addr_distinct", XW'(port_c_write_addr != port_d_write_addr), XW'(1));
      if (freeze) chk("we_in_freeze", XW'({port_c_we, port_d_we}), '0);
    end
  end

  // One clock of stimulus: inputs were set after the previous edge; acceptance is judged mid-cycle.
  task automatic step(output logic acc_a, output logic acc_l);
    @(negedge clk);
    acc_a = alu_valid && alu_ready;
    acc_l = ld_valid && ld_ready;
    if (freeze) chk("ready_in_freeze", XW'({alu_ready, ld_ready}), '0);
    if (acc_a) begin
      exp_c.push_back(ent_t'{alu_addr, alu_data});
      t_push_a = cyc;
    end
    if (acc_l) exp_d.push_back(ent_t'{ld_addr, ld_data});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [RW-1:0] ad,
                       input logic lv, input logic [AW-1:0] la, input logic [RW-1:0] ld);
    logic a_ok, l_ok;
    int   n;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_valid  = lv; ld_addr  = la; ld_data  = ld;
    n = 0;
    do begin
      step(a_ok, l_ok);
      if (a_ok) alu_valid = 1'b0;
      if (l_ok) ld_valid = 1'b0;
      n++;
    end while ((alu_valid || ld_valid) && n < 20);
    if (alu_valid || ld_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL drive_timeout: got no acceptance in 20 cycles, required acceptance");
    end
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    logic a_ok, l_ok;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    repeat (n) step(a_ok, l_ok);
  endtask

  task automatic wait_drain(input string nm);
    logic a_ok, l_ok;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    freeze    = 1'b0;
    for (int i = 0; i < 64 && (exp_c.size() != 0 || exp_d.size() != 0 || pending); i++)
      step(a_ok, l_ok);
    chk({nm, "_c_left"}, XW'(exp_c.size()), '0);
    chk({nm, "_d_left"}, XW'(exp_d.size()), '0);
    chk({nm, "_pending"}, XW'(pending), '0);
  endtask

  initial begin
    logic a_ok, l_ok;
    int   n0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_we", XW'({port_c_we, port_d_we}), '0);
    chk("rst_c_out", {port_c_write_addr, port_c_in}, '0);
    chk("rst_d_out", {port_d_write_addr, port_d_in}, '0);
    chk("rst_pending", XW'(pending), '0);
    chk("rst_ready", XW'({alu_ready, ld_ready}), XW'(2'b11));
    @(posedge clk);
    #1;

    // Basic ALU path
    drive(1'b1, 8'd15, RW'(2), 1'b0, '0, '0);
    idle(LAT + 2);
    chk("basic_latency", XW'(c_wr_cyc - t_push_a), XW'(LAT));
    chk("basic_no_d", XW'(n_d_wr), '0);

    // Dual drain in the same cycle
    drive(1'b1, 8'd3, RW'(7), 1'b1, 8'd9, RW'(11));
    idle(4);
    chk("dual_c_latency", XW'(c_wr_cyc - t_push_a), XW'(LAT));
    chk("dual_d_latency", XW'(d_wr_cyc - t_push_a), XW'(LAT));

    // Address conflict: load write trails the ALU write by one cycle
    drive(1'b1, 8'd12, RW'(5), 1'b1, 8'd12, RW'(6));
    idle(5);
    chk("conflict_c_latency", XW'(c_wr_cyc - t_push_a), XW'(LAT));
    chk("conflict_d_next", XW'(d_wr_cyc - c_wr_cyc), XW'(1));

    // Back-to-back loads with D draining
    for (int i = 0; i < 5; i++) drive(1'b0, '0, '0, 1'b1, AW'(i + 1), RW'(100 + i));
    idle(4);
    chk("ld_stream_drained", XW'(exp_d.size()), '0);

    // Same-address pairs keep the load side blocked until its FIFO is full
    for (int i = 0; i < 4; i++) drive(1'b1, 8'd5, RW'(200 + i), 1'b1, 8'd5, RW'(300 + i));
    freeze = 1'b1;
    d_cycles.delete();
    @(negedge clk);
    chk("ld_ready_full_frozen", XW'(ld_ready), '0);
    chk("pending_frozen", XW'(pending), XW'(1));
    @(posedge clk);
    #1;
    idle(2);
    freeze = 1'b0;
    idle(10);
    chk("ld_full_drain_count", XW'(d_cycles.size()), XW'(4));
    if (d_cycles.size() == 4) chk("ld_full_drain_consecutive", XW'(d_cycles[3] - d_cycles[0]), XW'(3));

    // Freeze in the middle of an ALU drain
    n0 = n_c_wr;
    for (int i = 0; i < 3; i++) drive(1'b1, AW'(20 + i), RW'(400 + i), 1'b0, '0, '0);
    for (int i = 0; i < 10 && n_c_wr == n0; i++) step(a_ok, l_ok);
    chk("freeze_first_write_seen", XW'(n_c_wr > n0), XW'(1));
    freeze = 1'b1;
    idle(3);
    freeze = 1'b0;
    idle(6);
    chk("freeze_drain_done", XW'(exp_c.size()), '0);

    // Reset with entries in flight
    drive(1'b1, 8'd30, RW'(500), 1'b1, 8'd31, RW'(501));
    drive(1'b1, 8'd32, RW'(502), 1'b1, 8'd33, RW'(503));
    reset = 1'b1;
    @(negedge clk);
    exp_c.delete();
    exp_d.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_pending", XW'(pending), '0);
    chk("midrst_ready", XW'({alu_ready, ld_ready}), XW'(2'b11));
    @(posedge clk);
    #1;
    idle(6);

    // Randomized traffic with frequent address clashes and sporadic freeze
    for (int i = 0; i < 400; i++) begin
      if (!alu_valid) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_addr  = AW'($urandom_range(0, 3));
        alu_data  = {9{$urandom}};
      end
      if (!ld_valid) begin
        ld_valid = 1'($urandom_range(0, 1));
        ld_addr  = AW'($urandom_range(0, 3));
        ld_data  = {9{$urandom}};
      end
      freeze = ($urandom_range(0, 7) == 0);
      step(a_ok, l_ok);
      if (a_ok) alu_valid = 1'b0;
      if (l_ok) ld_valid = 1'b0;
    end
    wait_drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_writeback_buffer.md
Name: regfile_writeback_buffer

Overview:
- Sits directly upstream of the regfile and owns its two write ports (C and D).
- Accepts results from two producers, the vector ALU and the load unit, each over a valid/ready handshake.
- Each producer has its own FIFO. The block drains up to two writes per cycle into the regfile and honours the global freeze.

Parameters:
- REG_CNT, 4, log2 of architectural register count; write address width = REG_CNT+LOG_SUPERSCALAR_WIDTH.
- LOG_SUPERSCALAR_WIDTH, 4, log2 of superscalar lanes; widens the address as in the regfile.
- REG_WIDTH, 288, data width per register write.
- FIFO_DEPTH, 4, entries per source FIFO; must be a power of two, at least 2.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- freeze  input  1  pipeline stall; holds all state.
- alu_valid  input  1  ALU result valid.
- alu_ready  output  1  ALU FIFO can accept this cycle.
- alu_addr  input  REG_CNT+LOG_SUPERSCALAR_WIDTH  ALU destination register.
- alu_data  input  REG_WIDTH  ALU result.
- ld_valid  input  1  load result valid.
- ld_ready  output  1  load FIFO can accept this cycle.
- ld_addr  input  REG_CNT+LOG_SUPERSCALAR_WIDTH  load destination register.
- ld_data  input  REG_WIDTH  load result.
- port_c_we  output  1  regfile write enable C (ALU path).
- port_c_write_addr  output  REG_CNT+LOG_SUPERSCALAR_WIDTH  write address C.
- port_c_in  output  REG_WIDTH  write data C.
- port_d_we  output  1  regfile write enable D (load path).
- port_d_write_addr  output  REG_CNT+LOG_SUPERSCALAR_WIDTH  write address D.
- port_d_in  output  REG_WIDTH  write data D.
- pending  output  1  any FIFO non-empty.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset state:
  - Both FIFOs empty, pointers and counts 0.
  - port_c_we=0 and port_d_we=0; addresses and data outputs 0.
  - pending=0.
  - alu_ready=1 and ld_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation discards all queued entries; nothing is written.
- Handshake:
  - ready = (count < FIFO_DEPTH) && !freeze.
  - ready never depends on valid.
  - Transfer happens when valid && ready at the rising edge.
  - Producers hold valid, addr and data until they see ready.
- Fixed mapping:
  - ALU FIFO head drains only to port C.
  - Load FIFO head drains only to port D.
- Drain outputs are registered. The head popped at edge N appears with we=1 in cycle N+1. Minimum push-to-write latency is 2 cycles.
- Pop rule for each FIFO: pop the head when non-empty && !freeze && !conflict (conflict applies to the load FIFO only).
- Conflict:
  - Both heads valid with equal addresses in the same cycle.
  - The ALU head pops; the load head waits one cycle.
  - The regfile never sees C and D targeting the same address in one cycle.
- Freeze:
  - No push, no pop, we outputs forced to 0.
  - FIFO contents and pointers held.
  - Drain resumes in the first cycle after freeze drops.
- Full: a FIFO at count==FIFO_DEPTH deasserts ready. A pop at that edge frees a slot visible next cycle. No same-cycle pass-through when full.
- Simultaneous push and pop on one FIFO: count unchanged, pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- Ordering: per-source FIFO order preserved. No ordering is guaranteed between sources except by the conflict rule.
- pending is registered and reflects the post-edge FIFO state.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - If a FIFO is empty and not frozen, an accepted push skips storage.
  - The pushed entry is registered straight onto its write port, so we=1 in the next cycle (1-cycle latency).
  - The conflict rule also applies between a bypassing load and the ALU head or ALU bypass; the load is then stored in its FIFO instead of bypassing.
- Undefined: all writes pass through the FIFO (2-cycle minimum latency).

Test Plan:
- Basic ALU path: after reset, ALU push (addr=15, data=2) for one cycle, no freeze → port_c_we=1, addr=15, data=2 exactly 2 cycles later (1 with WB_BYPASS_EN). port_d_we stays 0.
- Dual drain: ALU (addr=3, data=7) and load (addr=9, data=11) pushed in the same cycle → C and D written in the same later cycle with those values.
- Address conflict: ALU and load both push addr=12 (ALU data=5, load data=6) → C writes 5 in cycle T and D writes 6 in cycle T+1. C and D are never active on addr 12 together.
- Full/back-pressure: hold freeze=0 and push 5 load results back-to-back with D draining → no loss. With freeze=1 and 4 entries queued → ld_ready=0. After releasing freeze, all 4 entries drain in order, one per cycle.
- Freeze mid-drain: queue 3 ALU entries, assert freeze for 3 cycles after the first write → port_c_we=0 throughout freeze. The remaining 2 entries are written in order after freeze drops.
- Reset mid-operation: queue 2 entries per FIFO, assert reset for 1 cycle → no further writes, pending=0, both ready=1 afterwards.
